// File: rtl/bo_datapath.sv
// Operative datapath: working registers X/H/S, a 2-input add/multiply ALU with operand and
// write-back muxes, sticky overflow and an S-write counter that publishes a result.
// Optional feature macro: BO_SATURATE_EN (clamp overflowing writes instead of wrapping).
module bo_datapath #(
  parameter int             W             = 16,
  parameter logic [W-1:0]   K0            = 3,
  parameter logic [W-1:0]   K1            = 5,
  parameter int             LS_PER_RESULT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         LX,
  input  logic         LH,
  input  logic         LS,
  input  logic         Hula,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  output logic [W-1:0] h_out,
  output logic [W-1:0] s_out,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         ovf
);

  localparam logic [1:0] CNT_LAST = 2'(LS_PER_RESULT - 1);

  logic [W-1:0]   x_r;
  logic [W-1:0]   h_r;
  logic [W-1:0]   s_r;
  logic [W-1:0]   result_r;
  logic           result_valid_r;
  logic           ovf_r;
  logic [1:0]     cnt_r;

  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [W:0]     sum_full;
  logic [W:0]     diff_full;
  logic [2*W-1:0] prod_full;
  logic [2*W-1:0] alu_full;
  logic [W-1:0]   wb_raw;
  logic           wb_ovf;
  logic [W-1:0]   wb;
  logic           ovf_set;

`ifdef BO_SATURATE_EN
  // Negative differences clamp to zero; too-large sums and products clamp to all ones.
  function automatic logic [W-1:0] sat_value(input logic is_sub);
    return is_sub ? '0 : '1;
  endfunction
`endif

  always_comb begin
    opa = x_r;
    case (M0)
      2'd0:    opa = x_r;
      2'd1:    opa = h_r;
      2'd2:    opa = s_r;
      default: opa = K0;
    endcase
  end

  always_comb begin
    opb = K1;
    case (M1)
      2'd0:    opb = K1;
      2'd1:    opb = x_r;
      2'd2:    opb = h_r;
      default: opb = s_r;
    endcase
  end

  assign sum_full  = {1'b0, opa} + {1'b0, opb};
  assign diff_full = {1'b0, opa} - {1'b0, opb};
  assign prod_full = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
  assign alu_full  = Hula ? prod_full : {{(W-1){1'b0}}, sum_full};

  always_comb begin
    wb_raw = alu_full[W-1:0];
    wb_ovf = 1'b0;
    case (M2)
      2'd0: begin
        wb_raw = alu_full[W-1:0];
        wb_ovf = |alu_full[2*W-1:W];
      end
      2'd1:    wb_raw = opa;
      2'd2:    wb_raw = opb;
      default: begin
        wb_raw = diff_full[W-1:0];
        wb_ovf = diff_full[W];
      end
    endcase
  end

`ifdef BO_SATURATE_EN
  assign wb = wb_ovf ? sat_value(M2 == 2'd3) : wb_raw;
`else
  assign wb = wb_raw;
`endif

  // Overflow only counts when the write-back value is actually stored somewhere.
  assign ovf_set = (LH | LS) & wb_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r            <= '0;
      h_r            <= '0;
      s_r            <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      ovf_r          <= 1'b0;
      cnt_r          <= '0;
    end else begin
      if (LX) x_r <= x_in;
      if (LH) h_r <= wb;
      if (LS) s_r <= wb;

      if (ovf_set)  ovf_r <= 1'b1;
      else if (LX)  ovf_r <= 1'b0;

      // LX starts a new computation and suppresses any result on the same edge.
      result_valid_r <= 1'b0;
      if (LX) begin
        cnt_r <= '0;
      end else if (LS) begin
        if (cnt_r == CNT_LAST) begin
          cnt_r          <= '0;
          result_r       <= wb;
          result_valid_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + 2'd1;
        end
      end
    end
  end

  assign h_out        = h_r;
  assign s_out        = s_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign ovf          = ovf_r;

endmodule

// File: tb/tb_bo_datapath.sv
// Bench for bo_datapath: directed vector table, async-reset sequence, then random control
// words compared against an arithmetic reference model.
module tb_bo_datapath;

  localparam int LPR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] x_in = '0;
  logic        LX = 1'b0, LH = 1'b0, LS = 1'b0, Hula = 1'b0;
  logic [1:0]  M0 = '0, M1 = '0, M2 = '0;
  logic [15:0] h_out, s_out, result;
  logic        result_valid, ovf;

  bo_datapath #(.W(16), .K0(16'd3), .K1(16'd5), .LS_PER_RESULT(LPR)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .LX(LX), .LH(LH), .LS(LS), .Hula(Hula),
    .M0(M0), .M1(M1), .M2(M2), .h_out(h_out), .s_out(s_out), .result(result),
    .result_valid(result_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference model state
  longint m_x, m_h, m_s, m_res;
  int     m_cnt;
  bit     m_rv, m_ovf;

`ifdef BO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic model_reset();
    m_x = 0; m_h = 0; m_s = 0; m_res = 0; m_cnt = 0; m_rv = 0; m_ovf = 0;
  endtask

  task automatic model_step(input longint x, input bit lx, lh, ls, hula,
                            input int m0, m1, m2);
    longint a, b, full, val;
    bit o;
    a = (m0 == 0) ? m_x : (m0 == 1) ? m_h : (m0 == 2) ? m_s : 3;
    b = (m1 == 0) ? 5 : (m1 == 1) ? m_x : (m1 == 2) ? m_h : m_s;
    o = 0;
    if (m2 == 0) begin
      full = hula ? a * b : a + b;
      o = full > 65535;
      val = o ? (SAT ? 65535 : full % 65536) : full;
    end else if (m2 == 1) val = a;
    else if (m2 == 2) val = b;
    else begin
      full = a - b;
      o = full < 0;
      val = o ? (SAT ? 0 : full + 65536) : full;
    end
    if (lh) m_h = val;
    if (ls) m_s = val;
    if (lx) m_x = x;
    if ((lh || ls) && o) m_ovf = 1;
    else if (lx) m_ovf = 0;
    m_rv = 0;
    if (lx) m_cnt = 0;
    else if (ls) begin
      if (m_cnt == LPR - 1) begin
        m_res = val; m_rv = 1; m_cnt = 0;
      end else m_cnt++;
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic lx, lh, ls, hula,
                       input logic [1:0] m0, m1, m2);
    x_in = x; LX = lx; LH = lh; LS = ls; Hula = hula; M0 = m0; M1 = m1; M2 = m2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] x;
    logic        lx, lh, ls, hula;
    logic [1:0]  m0, m1, m2;
    logic [15:0] eh, es, er;
    logic        erv, eovf;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] x, input logic lx, lh, ls, hula,
                              input logic [1:0] m0, m1, m2,
                              input logic [15:0] eh, es, er, input logic erv, eovf);
    vec_t v;
    v.x = x; v.lx = lx; v.lh = lh; v.ls = ls; v.hula = hula;
    v.m0 = m0; v.m1 = m1; v.m2 = m2;
    v.eh = eh; v.es = es; v.er = er; v.erv = erv; v.eovf = eovf;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    logic [15:0] h7, s9, s10, h16;
    h7  = SAT ? 16'hFFFF : 16'hFFFE;
    s9  = SAT ? 16'h0000 : 16'hFFFD;
    s10 = s9;
    h16 = SAT ? 16'hFFFF : 16'd24464;
    //          x       lx lh ls hu m0 m1 m2   eh     es     er   rv ovf
    tbl[0]  = mk(16'd7,   1, 0, 0, 0, 0, 0, 0, 16'd0,  16'd0,  16'd0,  0, 0);
    tbl[1]  = mk(16'd0,   0, 1, 0, 0, 0, 0, 0, 16'd12, 16'd0,  16'd0,  0, 0);
    tbl[2]  = mk(16'd0,   0, 0, 1, 1, 0, 2, 0, 16'd12, 16'd84, 16'd0,  0, 0);
    tbl[3]  = mk(16'd0,   0, 0, 1, 0, 2, 0, 0, 16'd12, 16'd89, 16'd89, 1, 0);
    tbl[4]  = mk(16'd0,   0, 0, 0, 0, 0, 0, 0, 16'd12, 16'd89, 16'd89, 0, 0);
    tbl[5]  = mk(16'hFFFF,1, 0, 0, 0, 0, 0, 0, 16'd12, 16'd89, 16'd89, 0, 0);
    tbl[6]  = mk(16'd0,   0, 1, 0, 0, 0, 1, 0, h7,     16'd89, 16'd89, 0, 1);
    tbl[7]  = mk(16'd2,   1, 0, 0, 0, 0, 0, 0, h7,     16'd89, 16'd89, 0, 0);
    tbl[8]  = mk(16'd0,   0, 0, 1, 0, 0, 0, 3, h7,     s9,     16'd89, 0, 1);
    tbl[9]  = mk(16'd0,   0, 1, 1, 0, 3, 0, 1, 16'd3,  16'd3,  16'd3,  1, 1);
    tbl[10] = mk(16'd0,   0, 0, 1, 0, 0, 0, 2, 16'd3,  16'd5,  16'd3,  0, 1);
    tbl[11] = mk(16'd9,   1, 0, 1, 0, 0, 0, 1, 16'd3,  16'd2,  16'd3,  0, 0);
    tbl[12] = mk(16'd0,   0, 0, 1, 0, 0, 0, 2, 16'd3,  16'd5,  16'd3,  0, 0);
    tbl[13] = mk(16'd0,   0, 0, 1, 0, 0, 1, 2, 16'd3,  16'd9,  16'd9,  1, 0);
    tbl[14] = mk(16'd300, 1, 0, 0, 0, 0, 0, 0, 16'd3,  16'd9,  16'd9,  0, 0);
    tbl[15] = mk(16'd5,   1, 1, 0, 1, 0, 1, 0, h16,    16'd9,  16'd9,  0, 1);
    tbl[16] = mk(16'd0,   0, 0, 0, 0, 0, 0, 0, h16,    16'd9,  16'd9,  0, 1);
    if (s10 != s9) $display("note: table constants inconsistent");

    // Reset asserted from time 0, without any clock edge having mattered
    #1;
    chk("por_h", h_out, 0); chk("por_s", s_out, 0); chk("por_ovf", ovf, 0);
    #10 reset = 1'b1;

    // Load X=7, H=12, then assert reset between edges
    drive(16'd7, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(16'd0, 0, 1, 1, 0, 0, 0, 0); tick();
    chk("pre_rst_h", h_out, 12);
    drive(16'd0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_h", h_out, 0); chk("arst_s", s_out, 0); chk("arst_res", result, 0);
    chk("arst_rv", result_valid, 0); chk("arst_ovf", ovf, 0);
    #2 reset = 1'b1;
    model_reset();
    tick();
    chk("post_rst_h", h_out, 0);
    chk("post_rst_s", s_out, 0);

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].x, tbl[i].lx, tbl[i].lh, tbl[i].ls, tbl[i].hula, tbl[i].m0, tbl[i].m1, tbl[i].m2);
      model_step(tbl[i].x, tbl[i].lx, tbl[i].lh, tbl[i].ls, tbl[i].hula, tbl[i].m0, tbl[i].m1, tbl[i].m2);
      tick();
      chk($sformatf("v%0d_h", i), h_out, tbl[i].eh);
      chk($sformatf("v%0d_s", i), s_out, tbl[i].es);
      chk($sformatf("v%0d_res", i), result, tbl[i].er);
      chk($sformatf("v%0d_rv", i), result_valid, tbl[i].erv);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].eovf);
    end

    // Randomized control words against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x;
      logic lx, lh, ls, hu;
      logic [1:0] a, b, c;
      x  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      lx = ($urandom_range(0, 7) == 0);
      lh = 1'($urandom);
      ls = 1'($urandom);
      hu = 1'($urandom);
      a  = 2'($urandom); b = 2'($urandom); c = 2'($urandom);
      drive(x, lx, lh, ls, hu, a, b, c);
      model_step(x, lx, lh, ls, hu, a, b, c);
      tick();
      chk("rnd_h", h_out, 32'(m_h));
      chk("rnd_s", s_out, 32'(m_s));
      chk("rnd_res", result, 32'(m_res));
      chk("rnd_rv", result_valid, 32'(m_rv));
      chk("rnd_ovf", ovf, 32'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
